wts_slot_frontend: RTL and testbench
====================================

WTS_SLOT_FRONTEND -- requirements
Module: wts_slot_frontend

Interface
REQ-001 The block SHALL have these parameters: SYNC_STAGES, 2, slot strobe synchroniser depth (2..4).
REQ-002 The block SHALL have these parameters: IN_W, 12, core audio sample width, unsigned.
REQ-003 The block SHALL have these parameters: OUT_W, 16, output sample width, OUT_W >= IN_W.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Clock and reset ports: clk  input  1  system clock, 21.47727 MHz; reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have these slot bus ports: slot_a  input  16  address; slot_d_in  input  8  write data; slot_d_out  output  8  read data; slot_d_oe  output  1  data bus drive enable; slot_nsltsl, slot_nrd, slot_nwr  input  1 each  active-low strobes; slot_nint_oe  output  1  1 = pull INT low.
REQ-006 The block SHALL have these core ports: core_wrreq, core_rdreq  output  1  one-cycle requests; core_a  output  16; core_d  output  8; core_q  input  8  read data; core_nint  input  1  active-low interrupt.
REQ-007 The block SHALL have these audio ports: left_in, right_in  input  IN_W; sample_valid  input  1  new sample strobe; mode  input  2  00 stereo, 01 mono, 10 swap, 11 mute; left_out, right_out  output  OUT_W.

Function
REQ-008 The block SHALL pass slot_nsltsl, slot_nrd and slot_nwr each through SYNC_STAGES flops, plus one history flop per strobe.
REQ-009 A synchronised nwr 1->0 transition while synchronised nsltsl=0 SHALL assert core_wrreq for exactly one clk, SYNC_STAGES+1 cycles after the pin edge.
REQ-010 A synchronised nrd 1->0 transition while synchronised nsltsl=0 SHALL assert core_rdreq for exactly one clk, with the same timing.
REQ-011 On each request cycle, core_a and core_d SHALL show slot_a and slot_d_in, registered on the detect cycle and held until the next request.
REQ-012 If both strobes fall in the same cycle, only core_wrreq SHALL fire.
REQ-013 A strobe held low SHALL produce no further requests until it returns high.
REQ-014 The block SHALL capture core_q into slot_d_out the cycle after core_rdreq, set a read-valid flag, and assert slot_d_oe while read-valid=1, synchronised nrd=0 and nsltsl=0.
REQ-015 The block SHALL clear read-valid and deassert slot_d_oe the cycle after synchronised nrd or nsltsl goes high.
REQ-016 If nsltsl rises while a strobe is low, the block SHALL issue no request.
REQ-017 slot_nint_oe SHALL be the registered inverse of core_nint, with one cycle latency.
REQ-018 On sample_valid, the block SHALL sample mode and compute the outputs; left_out and right_out SHALL update on the next clk and hold between strobes.
REQ-019 Mono SHALL be (left_in+right_in) computed at IN_W+1 bits, then >>1 (truncate), driven to both channels.
REQ-020 Swap SHALL exchange the channels.
REQ-021 Mute SHALL output midscale 2^(OUT_W-1) on both channels.
REQ-022 Width extension SHALL left-justify the sample: {sample, (OUT_W-IN_W) zeros}.

Reset
REQ-023 While reset=1 at a clk edge, all sync and history flops SHALL be set to 1; core_wrreq, core_rdreq, slot_d_oe, slot_nint_oe and read-valid to 0; core_a, core_d and slot_d_out to 0; left_out and right_out to midscale.
REQ-024 Reset asserted mid-transaction SHALL abort it; after release, a strobe already low SHALL produce no request until it has been seen high.

Configuration
REQ-025 With WTS_SOFT_MUTE_EN defined, the block SHALL keep a 5-bit gain register (reset 16) that steps by 1 per sample_valid: toward 0 when mode=11, toward 16 otherwise.
REQ-026 With WTS_SOFT_MUTE_EN defined, each output SHALL be mid + ((x-mid)*gain)>>4, using signed arithmetic at OUT_W+6 bits, where x is the post-mode value and mode 11 uses the stereo path.
REQ-027 Without WTS_SOFT_MUTE_EN, mute SHALL take effect on the next sample and the gain logic SHALL be absent.

Verification
REQ-028 Write: slot_nsltsl=0, slot_a=16'h9800, slot_d_in=8'h5A, slot_nwr falls -> exactly one core_wrreq pulse 3 clk later, with core_a=9800 and core_d=5A; nwr held low 20 clk -> no second pulse.
REQ-029 Read: core_q=8'hC3, slot_nrd falls with nsltsl=0 -> core_rdreq 3 clk later, slot_d_oe=1 with slot_d_out=C3 one clk after that; nrd rises -> slot_d_oe=0 within SYNC_STAGES+1 clk.
REQ-030 Simultaneous nrd and nwr fall -> core_wrreq only; nsltsl=1 during strobes -> no requests and slot_d_oe stays 0.
REQ-031 Mono: left_in=12'hFFF, right_in=12'h001, mode=01, sample_valid -> both outputs 16'h8000 next clk; swap mode with left=0x123, right=0x456 -> left_out=0x4560, right_out=0x1230.
REQ-032 Mute without macro -> outputs 0x8000 after one sample; with WTS_SOFT_MUTE_EN and left_in=0xFFF -> left_out reaches 0x8000 after exactly 16 sample_valid strobes, passing 0xBFF8 at gain 8.
REQ-033 Reset during a read with slot_d_oe=1 -> slot_d_oe=0 and outputs=0x8000 next clk; nrd still low after release -> no core_rdreq.

Source files
------------

// File: rtl/wts_slot_frontend.sv
// rtl/wts_slot_frontend.sv - slot bus strobe synchroniser, core request generator and audio output stage
// Optional feature macro: WTS_SOFT_MUTE_EN (gain-ramped mute instead of an immediate midscale mute)
module wts_slot_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int IN_W        = 12,
  parameter int OUT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      slot_a,
  input  logic [7:0]       slot_d_in,
  output logic [7:0]       slot_d_out,
  output logic             slot_d_oe,
  input  logic             slot_nsltsl,
  input  logic             slot_nrd,
  input  logic             slot_nwr,
  output logic             slot_nint_oe,
  output logic             core_wrreq,
  output logic             core_rdreq,
  output logic [15:0]      core_a,
  output logic [7:0]       core_d,
  input  logic [7:0]       core_q,
  input  logic             core_nint,
  input  logic [IN_W-1:0]  left_in,
  input  logic [IN_W-1:0]  right_in,
  input  logic             sample_valid,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] left_out,
  output logic [OUT_W-1:0] right_out
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sltsl_sync, nrd_sync, nwr_sync;
  logic sltsl_hist, nrd_hist, nwr_hist;
  logic sltsl_s, nrd_s, nwr_s;
  logic nrd_armed, nwr_armed;
  logic [FILL_W-1:0] fill_cnt;
  logic fill_done;
  logic wr_fall, rd_fall;
  logic rd_valid;

  assign sltsl_s   = sltsl_sync[SYNC_STAGES-1];
  assign nrd_s     = nrd_sync[SYNC_STAGES-1];
  assign nwr_s     = nwr_sync[SYNC_STAGES-1];
  assign fill_done = (fill_cnt == FILL_W'(SYNC_STAGES));

  // Synchronise the three slot strobes and keep one history sample of each
  always_ff @(posedge clk) begin
    if (reset) begin
      sltsl_sync <= '1;
      nrd_sync   <= '1;
      nwr_sync   <= '1;
      sltsl_hist <= 1'b1;
      nrd_hist   <= 1'b1;
      nwr_hist   <= 1'b1;
    end else begin
      sltsl_sync <= {sltsl_sync[SYNC_STAGES-2:0], slot_nsltsl};
      nrd_sync   <= {nrd_sync[SYNC_STAGES-2:0], slot_nrd};
      nwr_sync   <= {nwr_sync[SYNC_STAGES-2:0], slot_nwr};
      sltsl_hist <= sltsl_s;
      nrd_hist   <= nrd_s;
      nwr_hist   <= nwr_s;
    end
  end

  // A strobe only arms once a genuine (post-reset) high level has emerged from the synchroniser,
  // so a strobe that was already low across reset cannot fake a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt  <= '0;
      nrd_armed <= 1'b0;
      nwr_armed <= 1'b0;
    end else begin
      if (!fill_done) fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_done && nrd_s) nrd_armed <= 1'b1;
      if (fill_done && nwr_s) nwr_armed <= 1'b1;
    end
  end

  // Falling edges count only while the slot was selected on both samples of the edge
  assign wr_fall = nwr_armed & nwr_hist & ~nwr_s & ~sltsl_s & ~sltsl_hist;
  assign rd_fall = nrd_armed & nrd_hist & ~nrd_s & ~sltsl_s & ~sltsl_hist;

  // Issue one-cycle core requests and latch address/data alongside them; write wins a tie
  always_ff @(posedge clk) begin
    if (reset) begin
      core_wrreq <= 1'b0;
      core_rdreq <= 1'b0;
      core_a     <= '0;
      core_d     <= '0;
    end else begin
      core_wrreq <= wr_fall;
      core_rdreq <= rd_fall & ~wr_fall;
      if (wr_fall || rd_fall) begin
        core_a <= slot_a;
        core_d <= slot_d_in;
      end
    end
  end

  // Capture read data after a read request and hold it valid until the bus cycle ends
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      slot_d_out <= '0;
    end else begin
      if (core_rdreq) slot_d_out <= core_q;
      if (nrd_s || sltsl_s) rd_valid <= 1'b0;
      else if (core_rdreq) rd_valid <= 1'b1;
    end
  end

  assign slot_d_oe = rd_valid & ~nrd_s & ~sltsl_s;

  // Interrupt pull-down follows the core interrupt one cycle late
  always_ff @(posedge clk) begin
    if (reset) slot_nint_oe <= 1'b0;
    else       slot_nint_oe <= ~core_nint;
  end

  logic [IN_W:0]    sum;
  logic [IN_W-1:0]  mix_l, mix_r;
  logic [OUT_W-1:0] ext_l, ext_r;
  logic [OUT_W-1:0] out_l_nxt, out_r_nxt;

`ifdef WTS_SOFT_MUTE_EN
  logic [4:0] gain, gain_nxt;

  function automatic logic [OUT_W-1:0] apply_gain(input logic [OUT_W-1:0] x, input logic [4:0] g);
    logic signed [OUT_W+5:0] diff, prod, res;
    diff = $signed({6'b0, x}) - $signed({6'b0, MID});
    prod = (diff * $signed({{(OUT_W+1){1'b0}}, g})) >>> 4;
    res  = prod + $signed({6'b0, MID});
    return res[OUT_W-1:0];
  endfunction

  // Gain ramps one step per sample toward 0 in mute, toward unity otherwise
  always_comb begin
    gain_nxt = gain;
    if (mode == 2'b11) begin
      if (gain != 5'd0) gain_nxt = gain - 5'd1;
    end else begin
      if (gain != 5'd16) gain_nxt = gain + 5'd1;
    end
  end

  // Gain register advances on each sample strobe
  always_ff @(posedge clk) begin
    if (reset)             gain <= 5'd16;
    else if (sample_valid) gain <= gain_nxt;
  end
`endif

  // Channel routing by mode, then left-justified widening
  always_comb begin
    sum   = {1'b0, left_in} + {1'b0, right_in};
    mix_l = left_in;
    mix_r = right_in;
    case (mode)
      2'b01: begin
        mix_l = IN_W'(sum >> 1);
        mix_r = IN_W'(sum >> 1);
      end
      2'b10: begin
        mix_l = right_in;
        mix_r = left_in;
      end
      default: ;
    endcase
    ext_l = OUT_W'(mix_l) << (OUT_W - IN_W);
    ext_r = OUT_W'(mix_r) << (OUT_W - IN_W);
`ifdef WTS_SOFT_MUTE_EN
    out_l_nxt = apply_gain(ext_l, gain_nxt);
    out_r_nxt = apply_gain(ext_r, gain_nxt);
`else
    out_l_nxt = (mode == 2'b11) ? MID : ext_l;
    out_r_nxt = (mode == 2'b11) ? MID : ext_r;
`endif
  end

  // Output samples update on the clock after a sample strobe and hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      left_out  <= MID;
      right_out <= MID;
    end else if (sample_valid) begin
      left_out  <= out_l_nxt;
      right_out <= out_r_nxt;
    end
  end

endmodule

// File: tb/tb_wts_slot_frontend.sv
// tb/tb_wts_slot_frontend.sv - self-checking bench for wts_slot_frontend
module tb_wts_slot_frontend;

  localparam int S  = 2;
  localparam int HN = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_in;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic        slot_nsltsl, slot_nrd, slot_nwr;
  logic        slot_nint_oe;
  logic        core_wrreq, core_rdreq;
  logic [15:0] core_a;
  logic [7:0]  core_d;
  logic [7:0]  core_q;
  logic        core_nint;
  logic [11:0] left_in, right_in;
  logic        sample_valid;
  logic [1:0]  mode;
  logic [15:0] left_out, right_out;

  wts_slot_frontend #(.SYNC_STAGES(S), .IN_W(12), .OUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
    .slot_nsltsl(slot_nsltsl), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr), .slot_nint_oe(slot_nint_oe),
    .core_wrreq(core_wrreq), .core_rdreq(core_rdreq), .core_a(core_a), .core_d(core_d),
    .core_q(core_q), .core_nint(core_nint),
    .left_in(left_in), .right_in(right_in), .sample_valid(sample_valid), .mode(mode),
    .left_out(left_out), .right_out(right_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit oe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pin-level history, one entry per clock edge
  bit h_rst[HN], h_nwr[HN], h_nrd[HN], h_nsl[HN];
  logic [15:0] h_a[HN];
  logic [7:0]  h_d[HN];
  int n = 0;

  logic        m_wr, m_rd, m_nint;
  logic [15:0] m_a, m_d16, m_l, m_r;
  int          m_gain = 16;

  function automatic bit fell(input int k, input bit wr);
    bit hi, lo;
    if (k < 0) return 0;
    for (int j = k; j <= k + S + 1; j++) if (h_rst[j]) return 0;
    hi = wr ? h_nwr[k] : h_nrd[k];
    lo = wr ? h_nwr[k+1] : h_nrd[k+1];
    return hi && !lo && !h_nsl[k] && !h_nsl[k+1];
  endfunction

  function automatic logic [15:0] scale(input int x, input int g);
    int p;
    p = ((x - 32768) * g) >>> 4;
    return 16'(32768 + p);
  endfunction

  // Model update at each edge from sampled pins, then compare just after the edge
  always @(posedge clk) begin
    int l, r, t;
    if (n < HN) begin
      h_rst[n] = reset; h_nwr[n] = slot_nwr; h_nrd[n] = slot_nrd; h_nsl[n] = slot_nsltsl;
      h_a[n] = slot_a; h_d[n] = slot_d_in;
      m_wr = fell(n - S - 1, 1'b1);
      m_rd = fell(n - S - 1, 1'b0) && !m_wr;
      m_nint = reset ? 1'b0 : ~core_nint;
      if (reset) begin
        m_a = 0; m_d16 = 0; m_l = 16'h8000; m_r = 16'h8000; m_gain = 16;
      end else begin
        if (m_wr || m_rd) begin m_a = slot_a; m_d16 = {8'h0, slot_d_in}; end
        if (sample_valid) begin
          l = int'(left_in) * 16; r = int'(right_in) * 16;
          if (mode == 2'b01) begin l = ((int'(left_in) + int'(right_in)) / 2) * 16; r = l; end
          if (mode == 2'b10) begin t = l; l = r; r = t; end
`ifdef WTS_SOFT_MUTE_EN
          if (mode == 2'b11) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
          else               m_gain = (m_gain < 16) ? m_gain + 1 : 16;
          m_l = scale(l, m_gain); m_r = scale(r, m_gain);
`else
          m_l = (mode == 2'b11) ? 16'h8000 : 16'(l);
          m_r = (mode == 2'b11) ? 16'h8000 : 16'(r);
`endif
        end
      end
      #1;
      check("wrreq", core_wrreq, m_wr);
      check("rdreq", core_rdreq, m_rd);
      check("core_a", core_a, m_a);
      check("core_d", core_d, m_d16[7:0]);
      check("nint_oe", slot_nint_oe, m_nint);
      check("left_out", left_out, m_l);
      check("right_out", right_out, m_r);
      if (core_wrreq) wr_cnt++;
      if (core_rdreq) rd_cnt++;
      if (slot_d_oe) oe_seen = 1;
      n++;
    end
  end

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_pulse(input string name, input bit wr, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #2;
      if ((wr && core_wrreq) || (!wr && core_rdreq)) begin lat = i; break; end
    end
    check(name, lat, exp_lat);
  endtask

  task automatic sample(input logic [11:0] l, input logic [11:0] r, input logic [1:0] md);
    left_in = l; right_in = r; mode = md; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    int c0, c1, lat;
    reset = 1; slot_a = 0; slot_d_in = 0; slot_nsltsl = 1; slot_nrd = 1; slot_nwr = 1;
    core_q = 8'hC3; core_nint = 1; left_in = 0; right_in = 0; sample_valid = 0; mode = 0;
    ticks(3);
    check("rst_oe", slot_d_oe, 1'b0);
    check("rst_dout", slot_d_out, 8'h00);
    check("rst_left", left_out, 16'h8000);
    reset = 0;
    ticks(6);

    // Write with held-low strobe
    slot_nsltsl = 0; ticks(2);
    slot_a = 16'h9800; slot_d_in = 8'h5A; c0 = wr_cnt; slot_nwr = 0;
    wait_pulse("wr_latency", 1'b1, 3);
    check("wr_core_a", core_a, 16'h9800);
    check("wr_core_d", core_d, 8'h5A);
    ticks(20);
    check("wr_single_pulse", wr_cnt - c0, 1);
    slot_nwr = 1; slot_a = 16'h1234; ticks(4);

    // Read
    c0 = rd_cnt; slot_a = 16'h9801; slot_nrd = 0;
    wait_pulse("rd_latency", 1'b0, 3);
    @(posedge clk); #2;
    check("rd_oe", slot_d_oe, 1'b1);
    check("rd_dout", slot_d_out, 8'hC3);
    @(negedge clk); slot_nrd = 1;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #2;
      if (!slot_d_oe) begin lat = i; break; end
    end
    check("rd_oe_release", (lat <= S + 1) ? 1 : 0, 1);
    check("rd_single_pulse", rd_cnt - c0, 1);
    ticks(4);

    // Simultaneous strobes: write only
    c0 = wr_cnt; c1 = rd_cnt;
    @(negedge clk); slot_nrd = 0; slot_nwr = 0;
    ticks(10);
    check("both_wr", wr_cnt - c0, 1);
    check("both_rd", rd_cnt - c1, 0);
    slot_nrd = 1; slot_nwr = 1; ticks(4);

    // Deselected slot: no requests, no drive
    slot_nsltsl = 1; ticks(4);
    c0 = wr_cnt; c1 = rd_cnt; oe_seen = 0;
    slot_nrd = 0; ticks(3); slot_nrd = 1; ticks(3); slot_nwr = 0; ticks(6);
    check("desel_wr", wr_cnt - c0, 0);
    check("desel_rd", rd_cnt - c1, 0);
    check("desel_oe", oe_seen, 1'b0);
    slot_nwr = 1; ticks(4);

    // Interrupt
    core_nint = 0; ticks(1);
    check("nint_low", slot_nint_oe, 1'b1);
    core_nint = 1; ticks(1);
    check("nint_high", slot_nint_oe, 1'b0);

    // Audio modes
    sample(12'hFFF, 12'h001, 2'b01);
    check("mono_l", left_out, 16'h8000);
    check("mono_r", right_out, 16'h8000);
    sample(12'h123, 12'h456, 2'b10);
    check("swap_l", left_out, 16'h4560);
    check("swap_r", right_out, 16'h1230);
    sample(12'hABC, 12'h123, 2'b00);
    check("stereo_l", left_out, 16'hABC0);
    left_in = 12'h777; ticks(3);
    check("hold_l", left_out, 16'hABC0);
`ifdef WTS_SOFT_MUTE_EN
    for (int i = 1; i <= 16; i++) begin
      sample(12'hFFF, 12'h000, 2'b11);
      if (i == 8)  check("soft_gain8", left_out, 16'hBFF8);
      if (i == 15) check("soft_gain1", left_out, 16'h87FF);
      if (i == 16) check("soft_gain0", left_out, 16'h8000);
    end
`else
    sample(12'hFFF, 12'h000, 2'b11);
    check("mute_l", left_out, 16'h8000);
    check("mute_r", right_out, 16'h8000);
`endif
    for (int i = 0; i < 17; i++) sample(12'h123, 12'h321, 2'b00);
    check("pre_rst_l", left_out, 16'h1230);

    // Reset during an active read
    slot_nsltsl = 0; ticks(3);
    slot_nrd = 0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #2;
      if (slot_d_oe) begin lat = i; break; end
    end
    check("rr_oe_seen", lat, 4);
    @(negedge clk); reset = 1;
    @(posedge clk); #2;
    check("rr_oe", slot_d_oe, 1'b0);
    check("rr_left", left_out, 16'h8000);
    check("rr_right", right_out, 16'h8000);
    @(negedge clk); reset = 0;
    c1 = rd_cnt;
    ticks(12);
    check("rr_no_req", rd_cnt - c1, 0);
    slot_nrd = 1; ticks(5);
    slot_nrd = 0; ticks(6);
    check("rr_rearm", rd_cnt - c1, 1);
    slot_nrd = 1; ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
